// File: rtl/top_level.sv
// ---------------------------------------------------------------------------
// top_level -- 5-bit pattern counting engine over a 32-byte message.
//
// The message (core[0..31]) is one 256-bit stream, core[0] bit 7 first.
// The pattern sits in core[32][7:3]. One run produces three counts:
//   ctb -> core[33] : matching windows that lie wholly inside one byte
//   cto -> core[34] : bytes holding at least one such in-byte match
//   cts -> core[35] : matching windows anywhere in the stream
//
// Ports
//   clk   : in  1 : sole clock, rising edge
//   start : in  1 : synchronous active-high reset and run request
//   done  : out 1 : high once core[33..35] hold this run's results
//
// Sub-module DataMem (instance dm1): 256 x 8 memory, asynchronous read,
// synchronous write.
// ---------------------------------------------------------------------------

module DataMem (
    input  logic       clk_i,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);
    logic [7:0] core [256];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            core[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = core[raddr_i];
endmodule

module top_level (
    input  logic clk,
    input  logic start,
    output logic done
);
    typedef enum logic [2:0] {IDLE, LOADP, SCAN, WR33, WR34, WR35, DONE} state_t;

    state_t     state_q;
    logic [4:0] pattern_q;
    logic [4:0] byteIdx_q;
    logic [7:0] prevByte_q;
    logic [7:0] ctb_q;
    logic [7:0] cto_q;
    logic [7:0] cts_q;
    logic       done_q;

    logic [7:0] ctb_d;
    logic [7:0] cto_d;
    logic [7:0] cts_d;

    logic [7:0]  memRaddr;
    logic [7:0]  memRdata;
    logic        memWe;
    logic [7:0]  memWaddr;
    logic [7:0]  memWdata;
    logic [2:0]  inCnt;
    logic [2:0]  crossCnt;
    logic [15:0] pairBits;

    DataMem dm1 (
        .clk_i   (clk),
        .we_i    (memWe),
        .waddr_i (memWaddr),
        .wdata_i (memWdata),
        .raddr_i (memRaddr),
        .rdata_o (memRdata)
    );

    // Read port points at the current message byte while scanning and at the
    // pattern word otherwise, so the pattern is ready on the IDLE exit edge.
    always_comb begin
        memRaddr = 8'd32;
        if (state_q == SCAN) begin
            memRaddr = {3'b000, byteIdx_q};
        end
    end

    // Match counting for one scan step. Bits [s+4:s] of the current byte are
    // the in-byte windows; bits [s+8:s+4] of {previous, current} are the four
    // windows straddling the byte boundary (k = 1..4 bits from the previous
    // byte). Byte 0 has no predecessor, so no straddling windows there.
    always_comb begin
        inCnt    = 3'd0;
        crossCnt = 3'd0;
        pairBits = {prevByte_q, memRdata};
        for (int s = 0; s < 4; s++) begin
            if (memRdata[s +: 5] == pattern_q) begin
                inCnt = inCnt + 3'd1;
            end
            if ((byteIdx_q != 5'd0) && (pairBits[s + 4 +: 5] == pattern_q)) begin
                crossCnt = crossCnt + 3'd1;
            end
        end
        ctb_d = ctb_q + {5'b00000, inCnt};
        cto_d = cto_q + {7'b0000000, (inCnt != 3'd0)};
        cts_d = cts_q + {5'b00000, inCnt} + {5'b00000, crossCnt};
    end

    // Result write-back. Gated by start so an abort never lands a write.
    always_comb begin
        memWe    = 1'b0;
        memWaddr = 8'd33;
        memWdata = 8'd0;
        case (state_q)
            WR33: begin
                memWe    = ~start;
                memWaddr = 8'd33;
                memWdata = ctb_q;
            end
            WR34: begin
                memWe    = ~start;
                memWaddr = 8'd34;
                memWdata = cto_q;
            end
            WR35: begin
                memWe    = ~start;
                memWaddr = 8'd35;
                memWdata = cts_q;
            end
            default: begin
                memWe = 1'b0;
            end
        endcase
    end

    // Control FSM. LOADP is a fixed one-cycle step so the run length never
    // depends on the data: 1 LOADP + 32 SCAN + 3 write cycles.
    always_ff @(posedge clk) begin
        if (start) begin
            state_q    <= IDLE;
            pattern_q  <= 5'd0;
            byteIdx_q  <= 5'd0;
            prevByte_q <= 8'd0;
            ctb_q      <= 8'd0;
            cto_q      <= 8'd0;
            cts_q      <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pattern_q <= memRdata[7:3];
                    state_q   <= LOADP;
                end
                LOADP: begin
                    state_q <= SCAN;
                end
                SCAN: begin
                    ctb_q      <= ctb_d;
                    cto_q      <= cto_d;
                    cts_q      <= cts_d;
                    prevByte_q <= memRdata;
                    byteIdx_q  <= byteIdx_q + 5'd1;
                    if (byteIdx_q == 5'd31) begin
                        state_q <= WR33;
                    end
                end
                WR33: begin
                    state_q <= WR34;
                end
                WR34: begin
                    state_q <= WR35;
                end
                WR35: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign done = done_q;
endmodule

// File: tb/tb_top_level.sv
// ---------------------------------------------------------------------------
// tb_top_level -- directed and random-data checks of the pattern counter.
// Expected counts come from hand-computed constants or from a bit-serial
// model that slides a 5-bit window along the flattened 256-bit stream.
// ---------------------------------------------------------------------------

module tb_top_level;
    logic clk   = 1'b0;
    logic start = 1'b1;
    logic done;

    int compareCount = 0;
    int failCount    = 0;

    logic [7:0] memImage [32];

    top_level dut (
        .clk   (clk),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    // One comparison point: counts it, and on a miss counts and reports it.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Loads the message image, pattern word and out-of-range sentinels.
    task automatic applyStimulus(input logic [7:0] patByte);
        for (int i = 0; i < 32; i++) begin
            dut.dm1.core[i] = memImage[i];
        end
        dut.dm1.core[32] = patByte;
        dut.dm1.core[33] = 8'hFF;
        dut.dm1.core[34] = 8'hFF;
        dut.dm1.core[35] = 8'hFF;
    endtask

    // Reference: walk every 5-bit window of the MSB-first stream.
    function automatic void modelCounts(input logic [4:0] pat, output int ctb,
                                        output int cto, output int cts);
        logic [255:0] stream;
        logic [31:0]  hit;
        for (int i = 0; i < 32; i++) begin
            stream[255 - 8 * i -: 8] = memImage[i];
        end
        ctb = 0;
        cts = 0;
        cto = 0;
        hit = '0;
        for (int j = 0; j < 252; j++) begin
            if (stream[255 - j -: 5] == pat) begin
                cts++;
                if ((j % 8) <= 3) begin
                    ctb++;
                    hit[j / 8] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 32; i++) begin
            cto += int'(hit[i]);
        end
    endfunction

    task automatic pulseStart(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, " done after start"}, int'(done), 0);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called with start already low; returns the edge (after the first
    // start-low edge) on which done rose, or 0 if it never did.
    task automatic waitDone(output int doneEdge);
        doneEdge = 0;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                doneEdge = n;
                break;
            end
        end
    endtask

    task automatic checkResults(input string tag, input int e33, input int e34, input int e35);
        checkOutput({tag, " ctb"}, int'(dut.dm1.core[33]), e33);
        checkOutput({tag, " cto"}, int'(dut.dm1.core[34]), e34);
        checkOutput({tag, " cts"}, int'(dut.dm1.core[35]), e35);
    endtask

    task automatic runDirected(input string tag, input logic [7:0] patByte,
                               input int e33, input int e34, input int e35);
        int doneEdge;
        applyStimulus(patByte);
        pulseStart(tag);
        waitDone(doneEdge);
        checkOutput({tag, " latency"}, doneEdge, 36);
        checkResults(tag, e33, e34, e35);
        checkOutput({tag, " core32 kept"}, int'(dut.dm1.core[32]), int'(patByte));
    endtask

    initial begin
        int doneEdge;
        int mCtb;
        int mCto;
        int mCts;
        logic [7:0] patByte;

        repeat (3) @(posedge clk);

        // All ones against 11111: every window matches.
        for (int i = 0; i < 32; i++) memImage[i] = 8'hFF;
        runDirected("ones", 8'hF8, 128, 32, 252);
        checkOutput("ones core0 kept", int'(dut.dm1.core[0]), 255);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("ones done held", int'(done), 1);
        checkOutput("ones cts held", int'(dut.dm1.core[35]), 252);

        // All zeros against 00000, then against 11111.
        for (int i = 0; i < 32; i++) memImage[i] = 8'h00;
        runDirected("zeros", 8'h00, 128, 32, 252);
        runDirected("zeros nomatch", 8'hF8, 0, 0, 0);

        // Only a boundary-crossing window matches; low pattern bits are junk.
        memImage[0] = 8'h07;
        memImage[1] = 8'hC0;
        runDirected("crossing", 8'hFD, 0, 0, 1);

        // Alternating bits against 10101: 2 per byte, windows at even offsets.
        for (int i = 0; i < 32; i++) memImage[i] = 8'hAA;
        runDirected("alternate", 8'hA8, 64, 32, 126);

        // start sampled high while in DONE drops done on that edge.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("done drop from DONE", int'(done), 0);

        // Abort mid-scan, swap in new data, and expect only the new counts.
        for (int i = 0; i < 32; i++) memImage[i] = 8'hFF;
        applyStimulus(8'hF8);
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort done low", int'(done), 0);
        for (int i = 0; i < 32; i++) memImage[i] = 8'($urandom);
        patByte = 8'($urandom);
        modelCounts(patByte[7:3], mCtb, mCto, mCts);
        applyStimulus(patByte);
        @(negedge clk);
        start = 1'b0;
        waitDone(doneEdge);
        checkOutput("abort latency", doneEdge, 36);
        checkResults("abort", mCtb, mCto, mCts);

        // Random messages and patterns against the stream model.
        for (int r = 0; r < 100; r++) begin
            for (int i = 0; i < 32; i++) memImage[i] = 8'($urandom);
            patByte = 8'($urandom);
            modelCounts(patByte[7:3], mCtb, mCto, mCts);
            applyStimulus(patByte);
            pulseStart($sformatf("rand%0d", r));
            waitDone(doneEdge);
            checkOutput($sformatf("rand%0d latency", r), doneEdge, 36);
            checkResults($sformatf("rand%0d", r), mCtb, mCto, mCts);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
